// File: rtl/hdmi_timing_pkg.sv
// Shared types and constants for the HDMI timing generator.
// Latency: n/a (types, constants and a pure lookup function only).
// Backpressure: n/a.
//
// Contents:
//   pixel_t      24-bit {R,G,B} pixel
//   state_t      generator run state (IDLE / RUN)
//   BAR_COLOURS  eight full-scale vertical colour bars, left to right
//   bar_colour() table lookup by bar index
package hdmi_timing_pkg;

   typedef logic [23:0] pixel_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int NUM_BARS = 8;

   // White, yellow, cyan, green, magenta, red, blue, black.
   localparam pixel_t BAR_COLOURS [NUM_BARS] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   function automatic pixel_t bar_colour(input logic [2:0] idx);
      return BAR_COLOURS[idx];
   endfunction

endpackage

// File: rtl/hdmi_timing_cnt.sv
// Raster position counters with region decode for the HDMI timing generator.
// Latency: counters are registered; region flags decode the current count combinationally.
// Backpressure: none; the counters advance on every cycle that run is high.
//
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   run          advance the raster; low clears both counters to 0
//   h_cnt/v_cnt  current horizontal / vertical position
//   active       inside the visible area
//   hsync/vsync  inside the sync regions (vsync covers whole lines)
//   frame_last   last cycle of the frame (h = H_TOTAL-1, v = V_TOTAL-1)
module hdmi_timing_cnt #(
   parameter  int H_ACTIVE = 1280,
   parameter  int H_FP     = 110,
   parameter  int H_SYNC   = 40,
   parameter  int H_BP     = 220,
   parameter  int V_ACTIVE = 720,
   parameter  int V_FP     = 5,
   parameter  int V_SYNC   = 5,
   parameter  int V_BP     = 20,
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW       = $clog2(H_TOTAL),
   localparam int VW       = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   output logic [HW-1:0] h_cnt,
   output logic [VW-1:0] v_cnt,
   output logic          active,
   output logic          hsync,
   output logic          vsync,
   output logic          frame_last
);

   // Region bounds held at 32 bits so an end bound equal to the total
   // (zero back porch) cannot alias to 0 when the total is a power of two.
   localparam logic [31:0] H_ACT_END  = 32'(H_ACTIVE);
   localparam logic [31:0] H_SYNC_BEG = 32'(H_ACTIVE + H_FP);
   localparam logic [31:0] H_SYNC_END = 32'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [31:0] H_LAST     = 32'(H_TOTAL - 1);
   localparam logic [31:0] V_ACT_END  = 32'(V_ACTIVE);
   localparam logic [31:0] V_SYNC_BEG = 32'(V_ACTIVE + V_FP);
   localparam logic [31:0] V_SYNC_END = 32'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [31:0] V_LAST     = 32'(V_TOTAL - 1);

   logic [31:0] h_pos;
   logic [31:0] v_pos;
   logic        h_last;
   logic        v_last;

   assign h_pos  = 32'(h_cnt);
   assign v_pos  = 32'(v_cnt);
   assign h_last = (h_pos == H_LAST);
   assign v_last = (v_pos == V_LAST);

   assign active     = (h_pos < H_ACT_END) && (v_pos < V_ACT_END);
   assign hsync      = (h_pos >= H_SYNC_BEG) && (h_pos < H_SYNC_END);
   assign vsync      = (v_pos >= V_SYNC_BEG) && (v_pos < V_SYNC_END);
   assign frame_last = h_last && v_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!run) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

endmodule

// File: rtl/hdmi_timing_gen.sv
// HDMI/DVI raster timing generator: pulls pixels from upstream and emits DE/HS/VS + RGB.
// Latency: pix_req is combinational with the raster position; all video outputs lag it by 1 cycle.
// Backpressure: none; a missing pixel (pix_valid low on pix_req) is sent black and flagged on underflow.
//
// Ports:
//   hdmi_clk, rst_n        pixel clock, asynchronous active-low reset
//   en                     run request; dropping it lets the current frame finish
//   pix_data, pix_valid    upstream {R,G,B} pixel and its valid
//   pix_req                pixel consumed this cycle (RUN and inside the active area)
//   hdmi_de/hs/vs/r/g/b    registered video outputs
//   sof                    marks output pixel (0,0)
//   underflow              requested pixel was not valid
//   busy                   generator is in RUN
//
// Build option: define TEST_PATTERN_EN to replace upstream pixels with eight
// vertical colour bars; pix_data/pix_valid are then ignored and underflow stays 0.
module hdmi_timing_gen
   import hdmi_timing_pkg::*;
#(
   parameter  int H_ACTIVE = 1280,
   parameter  int H_FP     = 110,
   parameter  int H_SYNC   = 40,
   parameter  int H_BP     = 220,
   parameter  int V_ACTIVE = 720,
   parameter  int V_FP     = 5,
   parameter  int V_SYNC   = 5,
   parameter  int V_BP     = 20,
   parameter  int SYNC_POL = 1,
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW       = $clog2(H_TOTAL),
   localparam int VW       = $clog2(V_TOTAL)
) (
   input  logic        hdmi_clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [23:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_req,
   output logic        hdmi_de,
   output logic        hdmi_hs,
   output logic        hdmi_vs,
   output logic [7:0]  hdmi_r,
   output logic [7:0]  hdmi_g,
   output logic [7:0]  hdmi_b,
   output logic        sof,
   output logic        underflow,
   output logic        busy
);

   localparam logic SYNC_ACT = (SYNC_POL != 0);

   state_t        state;
   logic          run;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          active;
   logic          hsync;
   logic          vsync;
   logic          frame_last;

   pixel_t        pix_next;
   logic          uf_next;
   pixel_t        pix_q;

   assign run     = (state == ST_RUN);
   assign busy    = run;
   assign pix_req = run && active;

   hdmi_timing_cnt #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_cnt (
      .clk        (hdmi_clk),
      .rst_n      (rst_n),
      .run        (run),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .active     (active),
      .hsync      (hsync),
      .vsync      (vsync),
      .frame_last (frame_last)
   );

   // Run control. Once started, a frame always completes: RUN is only left
   // on the final cycle of a frame, which is also when the counters wrap to 0.
   always_ff @(posedge hdmi_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (en) state <= ST_RUN;
            ST_RUN:  if (frame_last && !en) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef TEST_PATTERN_EN
   logic [2:0] bar_idx;

   // Bar index = h_cnt*8/H_ACTIVE; only meaningful while pix_req is high.
   assign bar_idx = 3'((32'(h_cnt) * 32'd8) / 32'(H_ACTIVE));

   always_comb begin
      pix_next = '0;
      uf_next  = 1'b0;
      if (pix_req) pix_next = bar_colour(bar_idx);
   end
`else
   // A requested-but-missing pixel goes out black with DE still high.
   always_comb begin
      pix_next = '0;
      uf_next  = 1'b0;
      if (pix_req) begin
         if (pix_valid) pix_next = pixel_t'(pix_data);
         else           uf_next  = 1'b1;
      end
   end
`endif

   // Video outputs describe the raster position of the previous cycle.
   always_ff @(posedge hdmi_clk or negedge rst_n) begin
      if (!rst_n) begin
         hdmi_de   <= 1'b0;
         hdmi_hs   <= !SYNC_ACT;
         hdmi_vs   <= !SYNC_ACT;
         pix_q     <= '0;
         sof       <= 1'b0;
         underflow <= 1'b0;
      end else begin
         hdmi_de   <= pix_req;
         hdmi_hs   <= (run && hsync) ? SYNC_ACT : !SYNC_ACT;
         hdmi_vs   <= (run && vsync) ? SYNC_ACT : !SYNC_ACT;
         pix_q     <= pix_next;
         sof       <= pix_req && (h_cnt == '0) && (v_cnt == '0);
         underflow <= uf_next;
      end
   end

   assign hdmi_r = pix_q[23:16];
   assign hdmi_g = pix_q[15:8];
   assign hdmi_b = pix_q[7:0];

endmodule
